// File: rtl/proto245_pkg.sv
// Shared types and default timing constants for the FT245-style async slave.
package proto245_pkg;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    RD_S   = 2'd1,
    WR_S   = 2'd2
  } proto245_slave_state_t;

  localparam int FT_RXF_PRECHARGE_DEF = 4;
  localparam int FT_TXE_PRECHARGE_DEF = 4;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered read data; rvalid follows an accepted rd by one cycle.
module fifo_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  input  logic              rd,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              empty
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic              wr_ok;
  logic              rd_ok;

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) && (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign wr_ok = wr && !full;
  assign rd_ok = rd && !empty;

  // Storage array and read data register carry no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[ADDR_W-1:0]] <= wdata;
    if (rd_ok) rdata <= mem[rptr[ADDR_W-1:0]];
  end

  // Pointers and read-valid flag; the extra pointer bit separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      rvalid <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      rvalid <= rd_ok;
    end
  end

endmodule

// File: rtl/proto245a_slave_sync.sv
// Two-flop synchronizers for the master's strobes and data, plus edge detection
// on the second synchronized stage. din_s is the data that sat alongside the
// previous strobe sample, so on a WR# rise it is the word from the last low cycle.
module proto245a_slave_sync #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdn,
  input  logic              wrn,
  input  logic [DATA_W-1:0] din,
  output logic              rd_fall,
  output logic              rd_rise,
  output logic              wr_fall,
  output logic              wr_rise,
  output logic              rdn_s,
  output logic              wrn_s,
  output logic [DATA_W-1:0] din_s
);

  logic              rdn_p0, rdn_p1, rdn_p2;
  logic              wrn_p0, wrn_p1, wrn_p2;
  logic [DATA_W-1:0] din_p0, din_p1, din_p2;

  // Synchronizer chain; the third stage only holds history for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdn_p0 <= 1'b1; rdn_p1 <= 1'b1; rdn_p2 <= 1'b1;
      wrn_p0 <= 1'b1; wrn_p1 <= 1'b1; wrn_p2 <= 1'b1;
      din_p0 <= '0;   din_p1 <= '0;   din_p2 <= '0;
    end else begin
      rdn_p0 <= rdn;    rdn_p1 <= rdn_p0; rdn_p2 <= rdn_p1;
      wrn_p0 <= wrn;    wrn_p1 <= wrn_p0; wrn_p2 <= wrn_p1;
      din_p0 <= din;    din_p1 <= din_p0; din_p2 <= din_p1;
    end
  end

  assign rdn_s   = rdn_p1;
  assign wrn_s   = wrn_p1;
  assign rd_fall = rdn_p2 && !rdn_p1;
  assign rd_rise = !rdn_p2 && rdn_p1;
  assign wr_fall = wrn_p2 && !wrn_p1;
  assign wr_rise = !wrn_p2 && wrn_p1;
  assign din_s   = din_p2;

endmodule

// File: rtl/proto245a_slave.sv
// FT245-style asynchronous FIFO slave: serves RD#/WR# from an async master
// out of an H2D buffer (with a one-word prefetch register) and into a D2H buffer.
module proto245a_slave
  import proto245_pkg::*;
#(
  parameter int DATA_W              = 8,
  parameter int H2D_FIFO_SIZE       = 512,
  parameter int D2H_FIFO_SIZE       = 512,
  parameter int RXF_PRECHARGE_TICKS = FT_RXF_PRECHARGE_DEF,
  parameter int TXE_PRECHARGE_TICKS = FT_TXE_PRECHARGE_DEF
) (
  input  logic              ft_clk,
  input  logic              ft_rst,
  input  logic              ft_rdn,
  input  logic              ft_wrn,
  input  logic [DATA_W-1:0] ft_din,
  output logic [DATA_W-1:0] ft_dout,
  output logic              ft_doe,
  output logic              ft_rxfn,
  output logic              ft_txen,
  input  logic [DATA_W-1:0] h2d_data,
  input  logic              h2d_wr,
  output logic              h2d_full,
  input  logic              d2h_rd,
  output logic [DATA_W-1:0] d2h_data,
  output logic              d2h_valid,
  output logic              d2h_empty,
  output logic              proto_err
);

  localparam int H2D_AW = $clog2(H2D_FIFO_SIZE);
  localparam int D2H_AW = $clog2(D2H_FIFO_SIZE);
  localparam int RXF_W  = $clog2(RXF_PRECHARGE_TICKS + 1);
  localparam int TXE_W  = $clog2(TXE_PRECHARGE_TICKS + 1);

  proto245_slave_state_t state, state_nxt;

  logic              rd_fall, rd_rise, wr_fall, wr_rise, rdn_s, wrn_s;
  logic [DATA_W-1:0] din_s;
  logic              both_low;
  logic [DATA_W-1:0] h2d_rdata;
  logic              h2d_rvalid, h2d_empty, h2d_rd;
  logic              d2h_full, d2h_push;
  logic [DATA_W-1:0] rd_word;
  logic              rd_word_vld;
  logic              rd_start, rd_end, wr_end;
  logic [RXF_W-1:0]  rxf_cnt;
  logic [TXE_W-1:0]  txe_cnt;

  function automatic logic [RXF_W-1:0] rxf_dec(input logic [RXF_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic logic [TXE_W-1:0] txe_dec(input logic [TXE_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  proto245a_slave_sync #(.DATA_W(DATA_W)) u_sync (
    .clk(ft_clk), .rst(ft_rst), .rdn(ft_rdn), .wrn(ft_wrn), .din(ft_din),
    .rd_fall(rd_fall), .rd_rise(rd_rise), .wr_fall(wr_fall), .wr_rise(wr_rise),
    .rdn_s(rdn_s), .wrn_s(wrn_s), .din_s(din_s)
  );

  fifo_sync #(.DATA_W(DATA_W), .ADDR_W(H2D_AW)) u_h2d (
    .clk(ft_clk), .rst(ft_rst), .wr(h2d_wr), .wdata(h2d_data), .full(h2d_full),
    .rd(h2d_rd), .rdata(h2d_rdata), .rvalid(h2d_rvalid), .empty(h2d_empty)
  );

  fifo_sync #(.DATA_W(DATA_W), .ADDR_W(D2H_AW)) u_d2h (
    .clk(ft_clk), .rst(ft_rst), .wr(d2h_push), .wdata(din_s), .full(d2h_full),
    .rd(d2h_rd), .rdata(d2h_data), .rvalid(d2h_valid), .empty(d2h_empty)
  );

  assign both_low = !rdn_s && !wrn_s;

  // State register.
  always_ff @(posedge ft_clk) begin
    if (ft_rst) state <= IDLE_S;
    else        state <= state_nxt;
  end

  // Next state: a read wins over a simultaneous write; a write is abandoned if RD# joins it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE_S: begin
        if (rd_fall && !ft_rxfn)                     state_nxt = RD_S;
        else if (wr_fall && !ft_txen && !both_low)   state_nxt = WR_S;
      end
      RD_S:    if (rd_rise) state_nxt = IDLE_S;
      WR_S:    if (both_low || wr_rise) state_nxt = IDLE_S;
      default: state_nxt = IDLE_S;
    endcase
  end

  // Flags and transfer strobes; flags are forced inactive while reset is held.
  always_comb begin
    ft_rxfn  = ft_rst || !((state == RD_S) ||
                           (rd_word_vld && state == IDLE_S && rxf_cnt == '0));
    ft_txen  = ft_rst || (state == WR_S) || d2h_full || (txe_cnt != '0);
    rd_start = (state == IDLE_S) && (state_nxt == RD_S);
    rd_end   = (state == RD_S) && rd_rise;
    wr_end   = (state == WR_S) && (state_nxt == IDLE_S);
    d2h_push = (state == WR_S) && wr_rise && !both_low;
    h2d_rd   = (state == IDLE_S) && !rd_word_vld && !h2d_rvalid && !h2d_empty;
  end

  // Prefetched word register: loaded from the H2D read port, no reset needed.
  always_ff @(posedge ft_clk) begin
    if (h2d_rvalid) rd_word <= h2d_rdata;
  end

  // Control path: prefetch valid, bus drive, precharge counters, sticky protocol error.
  always_ff @(posedge ft_clk) begin
    if (ft_rst) begin
      rd_word_vld <= 1'b0;
      ft_doe      <= 1'b0;
      ft_dout     <= '0;
      rxf_cnt     <= '0;
      txe_cnt     <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (h2d_rvalid) rd_word_vld <= 1'b1;
      if (rd_start) begin
        ft_doe  <= 1'b1;
        ft_dout <= rd_word;
      end
      if (rd_end) begin
        ft_doe      <= 1'b0;
        rd_word_vld <= 1'b0;
      end
      rxf_cnt <= rd_end ? RXF_W'(RXF_PRECHARGE_TICKS) : rxf_dec(rxf_cnt);
      txe_cnt <= wr_end ? TXE_W'(TXE_PRECHARGE_TICKS) : txe_dec(txe_cnt);
      if (both_low) proto_err <= 1'b1;
    end
  end

endmodule
